// File: rtl/l1_memory_banked.sv
// Dual-port L1 word memory with per-byte writes, selectable read latency,
// write-first cross-port collision handling and a zero-fill sweep after reset.
module l1_memory_banked #(
   parameter int unsigned ADDR_WIDTH     = 10,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned READ_LATENCY   = 1,
   parameter int unsigned IS_DUALPORT    = 1,
   parameter int unsigned CLEAR_ON_RESET = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   output logic                    ready,
   input  logic                    a_en,
   input  logic                    a_we,
   input  logic [DATA_WIDTH/8-1:0] a_be,
   input  logic [ADDR_WIDTH-1:0]   a_addr,
   input  logic [DATA_WIDTH-1:0]   a_wdata,
   output logic [DATA_WIDTH-1:0]   a_rdata,
   output logic                    a_rvalid,
   input  logic                    b_en,
   input  logic                    b_we,
   input  logic [DATA_WIDTH/8-1:0] b_be,
   input  logic [ADDR_WIDTH-1:0]   b_addr,
   input  logic [DATA_WIDTH-1:0]   b_wdata,
   output logic [DATA_WIDTH-1:0]   b_rdata,
   output logic                    b_rvalid,
   output logic                    b_ready
);

   localparam int unsigned NBYTES = DATA_WIDTH / 8;
   localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;
   localparam int unsigned CNT_W  = ADDR_WIDTH + 1;

   typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_e;

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        clr_cnt_q, clr_cnt_d;
   logic                    clr_we_c;
   logic                    ready_q;

   logic                    a_act, a_wr, a_rd;
   logic                    b_act, b_wr, b_rd;
   logic                    clr_wr;
   logic                    same_addr;
   logic [ADDR_WIDTH-1:0]   wa_addr;
   logic [DATA_WIDTH-1:0]   wa_data;
   logic [NBYTES-1:0]       wa_be, wb_be, wb_be_eff;
   logic [DATA_WIDTH-1:0]   a_rd_word, b_rd_word;

   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

   logic                    a_v1_q, a_v2_q, b_v1_q, b_v2_q;
   logic [DATA_WIDTH-1:0]   a_d1_q, a_d2_q, b_d1_q, b_d2_q;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
         clr_cnt_q <= '0;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         ready_q   <= (state_d == ST_RUN);
      end
   end

   // Next-state logic: sweep one word per cycle, leave after the last address
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      case (state_q)
         ST_CLEAR: begin
            clr_cnt_d = clr_cnt_q + CNT_W'(1);
            if (clr_cnt_q == CNT_W'(DEPTH - 1)) begin
               state_d = ST_RUN;
            end
         end
         default: ;
      endcase
   end

   // FSM outputs
   always_comb begin
      clr_we_c = 1'b0;
      if (state_q == ST_CLEAR) begin
         clr_we_c = 1'b1;
      end
   end

   // Request qualification; nothing is accepted while reset or not ready
   always_comb begin
      a_act  = ready_q & ~reset & a_en;
      a_wr   = a_act & a_we;
      a_rd   = a_act & ~a_we;
      b_act  = (IS_DUALPORT != 0) & ready_q & ~reset & b_en;
      b_wr   = b_act & b_we;
      b_rd   = b_act & ~b_we;
      clr_wr = clr_we_c & ~reset;
   end

   // Port A write path is shared with the clear sweep
   always_comb begin
      wa_addr   = clr_wr ? clr_cnt_q[ADDR_WIDTH-1:0] : a_addr;
      wa_data   = clr_wr ? '0 : a_wdata;
      wa_be     = clr_wr ? '1 : (a_wr ? a_be : '0);
      wb_be     = b_wr ? b_be : '0;
      same_addr = (a_addr == b_addr);
      wb_be_eff = wb_be & ~(((wa_addr == b_addr) ? wa_be : '0));
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NBYTES; i++) begin
         if (wa_be[i]) begin
            mem_q[wa_addr][8*i +: 8] <= wa_data[8*i +: 8];
         end
         if (wb_be_eff[i]) begin
            mem_q[b_addr][8*i +: 8] <= b_wdata[8*i +: 8];
         end
      end
   end

   // Read data with write-first bypass of the other port's same-cycle write
   always_comb begin
      a_rd_word = mem_q[a_addr];
      b_rd_word = mem_q[b_addr];
      for (int i = 0; i < NBYTES; i++) begin
         if (same_addr && wb_be[i]) begin
            a_rd_word[8*i +: 8] = b_wdata[8*i +: 8];
         end
         if (same_addr && a_wr && a_be[i]) begin
            b_rd_word[8*i +: 8] = a_wdata[8*i +: 8];
         end
      end
   end

   // Read pipeline; data registers only load on a completing read
   always_ff @(posedge clk) begin
      if (reset) begin
         a_v1_q <= 1'b0;
         a_v2_q <= 1'b0;
         b_v1_q <= 1'b0;
         b_v2_q <= 1'b0;
         a_d1_q <= '0;
         a_d2_q <= '0;
         b_d1_q <= '0;
         b_d2_q <= '0;
      end else begin
         a_v1_q <= a_rd;
         b_v1_q <= b_rd;
         a_v2_q <= a_v1_q;
         b_v2_q <= b_v1_q;
         if (a_rd) a_d1_q <= a_rd_word;
         if (b_rd) b_d1_q <= b_rd_word;
         if (a_v1_q) a_d2_q <= a_d1_q;
         if (b_v1_q) b_d2_q <= b_d1_q;
      end
   end

   assign a_rdata  = (READ_LATENCY >= 2) ? a_d2_q : a_d1_q;
   assign a_rvalid = (READ_LATENCY >= 2) ? a_v2_q : a_v1_q;
   assign b_rdata  = (READ_LATENCY >= 2) ? b_d2_q : b_d1_q;
   assign b_rvalid = (READ_LATENCY >= 2) ? b_v2_q : b_v1_q;
   assign ready    = ready_q;
   assign b_ready  = ready_q & (IS_DUALPORT != 0);

endmodule
